// File: rtl/pacman_pkg.sv
// Shared types, bus addresses, screen geometry and saturating position arithmetic
// for the Pac-Man sprite-position writer.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    WR_X = 3'd2,
    WR_Y = 3'd3,
    RD_X = 3'd4,
    RD_Y = 3'd5
  } state_t;

  localparam logic [7:0] KEY_UP    = 8'h77;
  localparam logic [7:0] KEY_DOWN  = 8'h73;
  localparam logic [7:0] KEY_LEFT  = 8'h61;
  localparam logic [7:0] KEY_RIGHT = 8'h64;

  localparam logic [31:0] ADDR_X = 32'd0;
  localparam logic [31:0] ADDR_Y = 32'd1;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int SPRITE = 32;

  // Moves toward zero by step, stopping at zero instead of wrapping.
  function automatic logic [9:0] sat_dec(input logic [9:0] value, input logic [10:0] step);
    logic [10:0] wide;
    wide = {1'b0, value};
    if (wide < step) begin
      return 10'd0;
    end else begin
      wide = wide - step;
      return wide[9:0];
    end
  endfunction

  // Moves away from zero by step, stopping at limit.
  function automatic logic [9:0] sat_inc(input logic [9:0] value, input logic [10:0] step,
                                         input logic [10:0] limit);
    logic [10:0] sum;
    sum = {1'b0, value} + step;
    if (sum > limit) begin
      return limit[9:0];
    end else begin
      return sum[9:0];
    end
  endfunction

endpackage

// File: rtl/pacman_position_writer_if.sv
// Memory-mapped register port toward the VGA controller's sprite-position registers.
interface pacman_position_writer_if;
  logic        memWr;
  logic [31:0] address;
  logic [31:0] datoOut;
  logic [31:0] datoIn;

  modport master (output memWr, output address, output datoOut, input datoIn);
  modport slave  (input memWr, input address, input datoOut, output datoIn);
endinterface

// File: rtl/pacman_position_writer_frame_tick.sv
// Brings the asynchronous active-low vsync into the clk domain and emits a one-cycle
// pulse on each synchronized falling edge.
module frame_tick_detector (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer plus delayed copy; resets high so no edge is seen at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= vsync;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = prev_q & ~sync2_q;

endmodule

// File: rtl/pacman_position_writer.sv
// Once per video frame: move the sprite by the current key, clamp to the screen,
// write X then Y to the VGA controller and read both back to confirm.
module pacman_position_writer
  import pacman_pkg::*;
#(
  parameter int STEP   = 2,
  parameter int INIT_X = 304,
  parameter int INIT_Y = 224,
  parameter int MAX_X  = H_RES - SPRITE,
  parameter int MAX_Y  = V_RES - SPRITE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vsync,
  input  logic [7:0]                        letra,
  pacman_position_writer_if.master          bus,
  output logic [9:0]                        pos_x,
  output logic [9:0]                        pos_y,
  output logic                              busy,
  output logic                              mismatch
);

  localparam logic [10:0] STEP_C   = 11'(STEP);
  localparam logic [10:0] MAX_X_C  = 11'(MAX_X);
  localparam logic [10:0] MAX_Y_C  = 11'(MAX_Y);
  localparam logic [9:0]  INIT_X_C = 10'(INIT_X);
  localparam logic [9:0]  INIT_Y_C = 10'(INIT_Y);

  state_t      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        pending_q, pending_d;
  logic        mismatch_q, mismatch_d;
  logic        busy_q, busy_d;
  logic        memwr_q, memwr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dout_q, dout_d;
  logic [9:0]  calc_x_s, calc_y_s;
  logic        tick_s;

  frame_tick_detector u_tick (
    .clk   (clk),
    .rst   (rst),
    .vsync (vsync),
    .tick  (tick_s)
  );

  // Candidate position for the latched key; only committed while in CALC.
  always_comb begin
    calc_x_s = pos_x_q;
    calc_y_s = pos_y_q;
    case (key_q)
      KEY_UP:    calc_y_s = sat_dec(pos_y_q, STEP_C);
      KEY_DOWN:  calc_y_s = sat_inc(pos_y_q, STEP_C, MAX_Y_C);
      KEY_LEFT:  calc_x_s = sat_dec(pos_x_q, STEP_C);
      KEY_RIGHT: calc_x_s = sat_inc(pos_x_q, STEP_C, MAX_X_C);
      default: begin
        calc_x_s = pos_x_q;
        calc_y_s = pos_y_q;
      end
    endcase
  end

  // Next state, pending-frame bookkeeping, position commit and read-back checking.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    mismatch_d = mismatch_q;

    // Ticks arriving mid-transaction collapse into a single deferred frame.
    if (tick_s && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (tick_s || pending_q) begin
          key_d     = letra;
          pending_d = 1'b0;
          state_d   = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        pos_x_d = calc_x_s;
        pos_y_d = calc_y_s;
        state_d = WR_X;
      end
      WR_X: state_d = WR_Y;
      WR_Y: state_d = RD_X;
      RD_X: begin
        if (bus.datoIn != {22'd0, pos_x_q}) begin
          mismatch_d = 1'b1;
        end else begin
          mismatch_d = mismatch_q;
        end
        state_d = RD_Y;
      end
      RD_Y: begin
        if (bus.datoIn != {22'd0, pos_y_q}) begin
          mismatch_d = 1'b1;
        end else begin
          mismatch_d = mismatch_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered and settled for
  // the whole cycle of the state they belong to.
  always_comb begin
    memwr_d = 1'b1;
    addr_d  = ADDR_X;
    dout_d  = dout_q;
    busy_d  = (state_d != IDLE);
    case (state_d)
      WR_X: begin
        memwr_d = 1'b0;
        addr_d  = ADDR_X;
        dout_d  = {22'd0, pos_x_d};
      end
      WR_Y: begin
        memwr_d = 1'b0;
        addr_d  = ADDR_Y;
        dout_d  = {22'd0, pos_y_d};
      end
      RD_X: addr_d = ADDR_X;
      RD_Y: addr_d = ADDR_Y;
      default: begin
        memwr_d = 1'b1;
        addr_d  = ADDR_X;
      end
    endcase
  end

  // State, position and bus registers; reset abandons any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      key_q      <= 8'h00;
      pos_x_q    <= INIT_X_C;
      pos_y_q    <= INIT_Y_C;
      pending_q  <= 1'b0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      memwr_q    <= 1'b1;
      addr_q     <= 32'd0;
      dout_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      pending_q  <= pending_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      memwr_q    <= memwr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.memWr   = memwr_q;
  assign bus.address = addr_q;
  assign bus.datoOut = dout_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign busy        = busy_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_pacman_position_writer.sv
// Directed bench: a register-file responder, a write monitor, and a scoreboard of
// expected X/Y writes computed from an independent position model.
module tb_pacman_position_writer;
  import pacman_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic [7:0] letra;
  logic [9:0] pos_x, pos_y;
  logic       busy, mismatch;
  logic       corrupt;

  pacman_position_writer_if bus ();

  pacman_position_writer dut (
    .clk      (clk),
    .rst      (rst),
    .vsync    (vsync),
    .letra    (letra),
    .bus      (bus),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  // Responder register file and write monitor, both on the negedge capture point.
  logic [31:0] reg_x = 32'd0;
  logic [31:0] reg_y = 32'd0;
  logic [31:0] obs_addr [0:2047];
  logic [31:0] obs_data [0:2047];
  int wr_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (bus.memWr === 1'b0) begin
      if (bus.address == 32'd0) reg_x <= bus.datoOut;
      else reg_y <= bus.datoOut;
      if (wr_cnt < 2048) begin
        obs_addr[wr_cnt] <= bus.address;
        obs_data[wr_cnt] <= bus.datoOut;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign bus.datoIn = (corrupt && bus.address == 32'd0) ? 32'h0000_0400 :
                      ((bus.address == 32'd0) ? reg_x : reg_y);

  int checks = 0;
  int errors = 0;
  int rd_idx = 0;
  int mx, my;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent position model with clamping at 0 and the screen maximum.
  task automatic model_step(input logic [7:0] key);
    if (key == 8'h61) mx = (mx >= 2) ? mx - 2 : 0;
    else if (key == 8'h64) mx = (mx + 2 > 608) ? 608 : mx + 2;
    else if (key == 8'h77) my = (my >= 2) ? my - 2 : 0;
    else if (key == 8'h73) my = (my + 2 > 448) ? 448 : my + 2;
  endtask

  task automatic push_xy();
    exp_addr_q.push_back(32'd0); exp_data_q.push_back(32'(mx));
    exp_addr_q.push_back(32'd1); exp_data_q.push_back(32'(my));
  endtask

  task automatic drain();
    while (rd_idx < wr_cnt) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write", obs_addr[rd_idx], 32'hFFFF_FFFF);
      end else begin
        chk("wr_addr", obs_addr[rd_idx], exp_addr_q.pop_front());
        chk("wr_data", obs_data[rd_idx], exp_data_q.pop_front());
      end
      rd_idx++;
    end
    chk("missing_writes", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic frame(input logic [7:0] key);
    letra = key;
    model_step(key);
    push_xy();
    @(posedge clk); #1 vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_after_frame", 32'(busy), 32'd0);
    drain();
    chk("pos_x", 32'(pos_x), 32'(mx));
    chk("pos_y", 32'(pos_y), 32'(my));
  endtask

  int b0, w0, n;
  logic found;

  initial begin
    rst = 1'b0; vsync = 1'b1; letra = 8'h00; corrupt = 1'b0;
    mx = 304; my = 224;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memWr", 32'(bus.memWr), 32'd1);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_datoOut", bus.datoOut, 32'd0);
    chk("rst_pos_x", 32'(pos_x), 32'd304);
    chk("rst_pos_y", 32'(pos_y), 32'd224);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // First frame with a non-movement key: one write each, five busy cycles.
    b0 = busy_cnt; w0 = wr_cnt;
    frame(8'h00);
    chk("busy_cycles", 32'(busy_cnt - b0), 32'd5);
    chk("memWr_low_cycles", 32'(wr_cnt - w0), 32'd2);
    chk("mismatch_clean", 32'(mismatch), 32'd0);

    for (int i = 0; i < 3; i++) frame(KEY_RIGHT);
    chk("x_after_right", 32'(pos_x), 32'd310);

    // Walk left to the edge, then keep pushing outward.
    n = 0;
    while (mx != 0 && n < 400) begin frame(KEY_LEFT); n++; end
    frame(KEY_LEFT);
    frame(KEY_LEFT);
    chk("x_low_clamp", 32'(pos_x), 32'd0);

    n = 0;
    while (my != 448 && n < 400) begin frame(KEY_DOWN); n++; end
    frame(KEY_DOWN);
    frame(KEY_DOWN);
    chk("y_high_clamp", 32'(pos_y), 32'd448);

    // Burst of vsync falls while a frame is in flight collapses into one extra frame.
    letra = KEY_UP;
    model_step(KEY_UP); push_xy();
    model_step(KEY_UP); push_xy();
    w0 = wr_cnt;
    @(posedge clk); #1 vsync = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1 vsync = (i % 2 == 1) ? 1'b1 : 1'b0;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("burst_writes", 32'(wr_cnt - w0), 32'd4);
    repeat (20) @(posedge clk);
    #1;
    chk("burst_no_more", 32'(wr_cnt - w0), 32'd4);
    chk("burst_idle", 32'(busy), 32'd0);
    drain();
    chk("burst_pos_y", 32'(pos_y), 32'(my));

    // Corrupted X read-back sets a sticky error flag.
    corrupt = 1'b1;
    frame(8'h00);
    corrupt = 1'b0;
    chk("mismatch_set", 32'(mismatch), 32'd1);
    frame(8'h00);
    chk("mismatch_sticky", 32'(mismatch), 32'd1);

    // Reset in the middle of the Y write.
    letra = KEY_RIGHT;
    model_step(KEY_RIGHT);
    exp_addr_q.push_back(32'd0); exp_data_q.push_back(32'(mx));
    found = 1'b0;
    @(posedge clk); #1 vsync = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.memWr === 1'b0 && bus.address == 32'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("wr_y_reached", 32'(found), 32'd1);
    vsync = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_memWr", 32'(bus.memWr), 32'd1);
    chk("midrst_pos_x", 32'(pos_x), 32'd304);
    chk("midrst_pos_y", 32'(pos_y), 32'd224);
    chk("midrst_mismatch", 32'(mismatch), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    drain();
    mx = 304; my = 224;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    frame(8'h00);
    chk("post_rst_mismatch", 32'(mismatch), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
